// File: rtl/uart_cmd_sequencer.sv
// Command sequencer between uart_top and a combinational ALU: pops an A, B, opcode frame,
// runs the ALU on registered operands and pushes the one-byte result back to the TX FIFO.
module uart_cmd_sequencer #(
    parameter int DBIT    = 8,
    parameter int OP_W    = 6,
    parameter int TIMEOUT = 65536
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx_empty,
    input  logic [DBIT-1:0] i_r_data,
    output logic            o_rd_uart,
    input  logic            i_tx_full,
    output logic            o_wr_uart,
    output logic [DBIT-1:0] o_w_data,
    output logic [DBIT-1:0] o_alu_a,
    output logic [DBIT-1:0] o_alu_b,
    output logic [OP_W-1:0] o_alu_op,
    input  logic [DBIT-1:0] i_alu_result,
    output logic            o_busy,
    output logic            o_err,
    output logic [7:0]      o_cmd_cnt
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TMO_EN = (TIMEOUT != 0);

    typedef enum logic [2:0] {S_A, S_B, S_OP, S_EXEC, S_SEND} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] tmo_cnt;
    logic          in_read;
    logic          in_wait;
    logic          take;
    logic          tmo_hit;
    logic          push_next;

    assign in_read = (state == S_A) || (state == S_B) || (state == S_OP);
    assign in_wait = (state == S_B) || (state == S_OP);
    assign take    = in_read && !i_rx_empty;
    // The abort fires on the empty cycle that would bring the count to TIMEOUT; a byte present then wins.
    assign tmo_hit = TMO_EN && in_wait && i_rx_empty && (tmo_cnt == TMO_LAST);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            S_A:     if (take) state_next = S_B;
            S_B:     if (take) state_next = S_OP;   else if (tmo_hit) state_next = S_A;
            S_OP:    if (take) state_next = S_EXEC; else if (tmo_hit) state_next = S_A;
            S_EXEC:  state_next = S_SEND;
            S_SEND:  if (o_wr_uart) state_next = S_A;
            default: state_next = S_A;
        endcase
    end

    always_comb begin
        o_rd_uart = i_reset && take;
        // Lookahead: o_wr_uart is a flop, so decide the push one clock early. Only this block
        // writes the TX FIFO, so a not-full FIFO cannot turn full before our own push lands.
        push_next = (state_next == S_SEND) && !i_tx_full;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_op  <= '0;
            o_w_data  <= '0;
            o_wr_uart <= 1'b0;
            o_err     <= 1'b0;
            o_busy    <= 1'b0;
            o_cmd_cnt <= '0;
            tmo_cnt   <= '0;
        end else begin
            if (take) begin
                case (state)
                    S_A:     o_alu_a  <= i_r_data;
                    S_B:     o_alu_b  <= i_r_data;
                    S_OP:    o_alu_op <= i_r_data[OP_W-1:0];
                    default: ;
                endcase
            end
            if (state == S_EXEC) o_w_data <= i_alu_result;
            if (o_wr_uart) o_cmd_cnt <= o_cmd_cnt + 8'd1;
            o_wr_uart <= push_next;
            o_err     <= tmo_hit;
            o_busy    <= (state_next != S_A);
            if (TMO_EN && in_wait && i_rx_empty && !tmo_hit) tmo_cnt <= tmo_cnt + CW'(1);
            else tmo_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Bench for uart_cmd_sequencer: queue-based RX FIFO, ADD/SUB ALU, frame-level expected results.
module tb_uart_cmd_sequencer;

    localparam int DBIT = 8;
    localparam int OP_W = 6;
    localparam int TMO  = 16;

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b0;
    logic            i_rx_empty = 1'b1;
    logic [DBIT-1:0] i_r_data = '0;
    logic            i_tx_full = 1'b0;
    logic [DBIT-1:0] i_alu_result;
    logic            o_rd_uart;
    logic            o_wr_uart;
    logic [DBIT-1:0] o_w_data;
    logic [DBIT-1:0] o_alu_a;
    logic [DBIT-1:0] o_alu_b;
    logic [OP_W-1:0] o_alu_op;
    logic            o_busy;
    logic            o_err;
    logic [7:0]      o_cmd_cnt;

    uart_cmd_sequencer #(.DBIT(DBIT), .OP_W(OP_W), .TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_rx_empty(i_rx_empty), .i_r_data(i_r_data),
        .o_rd_uart(o_rd_uart), .i_tx_full(i_tx_full), .o_wr_uart(o_wr_uart), .o_w_data(o_w_data),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .i_alu_result(i_alu_result),
        .o_busy(o_busy), .o_err(o_err), .o_cmd_cnt(o_cmd_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Environment ALU: 0x20 adds, 0x22 subtracts, anything else yields 0.
    always_comb begin
        i_alu_result = '0;
        if (o_alu_op == 6'h20) i_alu_result = o_alu_a + o_alu_b;
        else if (o_alu_op == 6'h22) i_alu_result = o_alu_a - o_alu_b;
    end

    logic [7:0] rx_q[$];
    int         pop_log[$];
    int         wr_cyc[$];
    logic [7:0] wr_dat[$];
    int         err_log[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_cnt = 8'd0;

    task automatic drive_rx();
        i_rx_empty = (rx_q.size() == 0);
        i_r_data   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    endtask

    task automatic clear_logs();
        pop_log.delete();
        wr_cyc.delete();
        wr_dat.delete();
        err_log.delete();
    endtask

    // One clock: note the pop request at the negedge, let the edge happen, then update the FIFO
    // model and log the registered outputs 1 ns after the edge.
    task automatic step();
        logic rd_pre;
        @(negedge i_clk);
        rd_pre = o_rd_uart;
        @(posedge i_clk);
        cyc++;
        #1;
        if (rd_pre) begin
            n_checks++;
            if (rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_on_empty: o_rd_uart=1 with FIFO empty in cycle %0d", cyc - 1);
            end else begin
                pop_log.push_back(cyc - 1);
                void'(rx_q.pop_front());
            end
        end
        drive_rx();
        if (o_wr_uart) begin
            wr_cyc.push_back(cyc);
            wr_dat.push_back(o_w_data);
        end
        if (o_err) err_log.push_back(cyc);
    endtask

    task automatic run_quiet(input int budget, input string tag);
        int k;
        k = 0;
        while ((rx_q.size() != 0 || o_busy) && k < budget) begin
            step();
            k++;
        end
        n_checks++;
        if (rx_q.size() != 0 || o_busy) begin
            n_fail++;
            $display("FAIL %s_drain: still busy after %0d cycles, required idle", tag, budget);
        end
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        rx_q.push_back(a);
        rx_q.push_back(b);
        rx_q.push_back(op);
        drive_rx();
    endtask

    task automatic wait_pops(input int want, input int budget, input string tag);
        int k;
        k = 0;
        while (pop_log.size() < want && k < budget) begin
            step();
            k++;
        end
        n_checks++;
        if (pop_log.size() < want) begin
            n_fail++;
            $display("FAIL %s_pops: got %0d pops, required %0d", tag, pop_log.size(), want);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({o_rd_uart, o_wr_uart, o_busy, o_err} !== 4'b0000 || o_cmd_cnt !== 8'd0 ||
            o_w_data !== 8'd0 || o_alu_a !== 8'd0 || o_alu_b !== 8'd0 || o_alu_op !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rd=%b wr=%b busy=%b err=%b cnt=%0d wd=%h a=%h b=%h op=%h, required all 0",
                     o_rd_uart, o_wr_uart, o_busy, o_err, o_cmd_cnt, o_w_data, o_alu_a, o_alu_b, o_alu_op);
        end
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
    endtask

    task automatic test_single();
        clear_logs();
        push_frame(8'h05, 8'h03, 8'h20);
        run_quiet(50, "single");
        exp_cnt = exp_cnt + 8'd1;
        n_checks++;
        if (pop_log.size() != 3 || pop_log[1] != pop_log[0] + 1 || pop_log[2] != pop_log[0] + 2) begin
            n_fail++;
            $display("FAIL single_pops: %0d pops not in consecutive cycles, required 3 back-to-back", pop_log.size());
        end
        n_checks++;
        if (wr_dat.size() != 1 || wr_dat[0] !== 8'h08) begin
            n_fail++;
            $display("FAIL single_write: %0d writes (first %h), required one write of 08",
                     wr_dat.size(), (wr_dat.size() > 0) ? wr_dat[0] : 8'hxx);
        end else begin
            n_checks++;
            if (pop_log.size() == 3 && wr_cyc[0] != pop_log[2] + 2) begin
                n_fail++;
                $display("FAIL single_latency: write %0d cycles after opcode pop, required 2", wr_cyc[0] - pop_log[2]);
            end
        end
        n_checks++;
        if (o_cmd_cnt !== exp_cnt || o_alu_a !== 8'h05 || o_alu_b !== 8'h03 || o_alu_op !== 6'h20) begin
            n_fail++;
            $display("FAIL single_regs: cnt=%0d a=%h b=%h op=%h, required cnt=%0d a=05 b=03 op=20",
                     o_cmd_cnt, o_alu_a, o_alu_b, o_alu_op, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        push_frame(8'h05, 8'h03, 8'h20);
        push_frame(8'h09, 8'h04, 8'h22);
        run_quiet(80, "b2b");
        exp_cnt = exp_cnt + 8'd2;
        n_checks++;
        if (wr_dat.size() != 2 || pop_log.size() != 6) begin
            n_fail++;
            $display("FAIL b2b_counts: %0d writes %0d pops, required 2 writes 6 pops", wr_dat.size(), pop_log.size());
        end else begin
            n_checks++;
            if (wr_dat[0] !== 8'h08 || wr_dat[1] !== 8'h05) begin
                n_fail++;
                $display("FAIL b2b_data: got %h,%h, required 08,05", wr_dat[0], wr_dat[1]);
            end
            n_checks++;
            if (wr_cyc[0] != pop_log[2] + 2 || wr_cyc[1] != pop_log[5] + 2) begin
                n_fail++;
                $display("FAIL b2b_latency: %0d,%0d cycles after opcode pops, required 2,2",
                         wr_cyc[0] - pop_log[2], wr_cyc[1] - pop_log[5]);
            end
            n_checks++;
            if (pop_log[3] != pop_log[0] + 5) begin
                n_fail++;
                $display("FAIL b2b_throughput: %0d cycles between frames, required 5", pop_log[3] - pop_log[0]);
            end
        end
        n_checks++;
        if (o_cmd_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL b2b_cnt: got %0d, required %0d", o_cmd_cnt, exp_cnt);
        end
    endtask

    task automatic test_timeout();
        int k;
        clear_logs();
        rx_q.push_back(8'h05);
        drive_rx();
        k = 0;
        while (err_log.size() == 0 && k < 40) begin
            step();
            k++;
        end
        n_checks++;
        if (err_log.size() != 1 || pop_log.size() != 1) begin
            n_fail++;
            $display("FAIL tmo_err: %0d err pulses %0d pops, required 1 and 1", err_log.size(), pop_log.size());
        end else begin
            // 16 edges after the edge that captured A, i.e. 17 cycles after the pop cycle.
            n_checks++;
            if (err_log[0] != pop_log[0] + TMO + 1) begin
                n_fail++;
                $display("FAIL tmo_time: o_err %0d cycles after A pop, required %0d", err_log[0] - pop_log[0], TMO + 1);
            end
            n_checks++;
            if (o_busy !== 1'b0 || wr_dat.size() != 0 || o_alu_a !== 8'h05) begin
                n_fail++;
                $display("FAIL tmo_state: busy=%b writes=%0d a=%h, required busy=0 writes=0 a=05",
                         o_busy, wr_dat.size(), o_alu_a);
            end
        end
        step();
        n_checks++;
        if (o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_pulse: o_err=%b one cycle later, required 0", o_err);
        end
        clear_logs();
        push_frame(8'hFF, 8'h01, 8'h20);
        run_quiet(50, "tmo_after");
        exp_cnt = exp_cnt + 8'd1;
        n_checks++;
        if (wr_dat.size() != 1 || wr_dat[0] !== 8'h00 || o_cmd_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL tmo_recover: %0d writes (first %h) cnt=%0d, required one write of 00 cnt=%0d",
                     wr_dat.size(), (wr_dat.size() > 0) ? wr_dat[0] : 8'hxx, o_cmd_cnt, exp_cnt);
        end
    endtask

    task automatic test_timeout_edge();
        int n;
        clear_logs();
        rx_q.push_back(8'h09);
        drive_rx();
        wait_pops(1, 10, "tmo_edge");
        n = (pop_log.size() > 0) ? pop_log[0] : cyc;
        while (cyc < n + TMO) step();
        rx_q.push_back(8'h04);
        rx_q.push_back(8'h22);
        drive_rx();
        run_quiet(50, "tmo_edge");
        exp_cnt = exp_cnt + 8'd1;
        n_checks++;
        if (err_log.size() != 0 || wr_dat.size() != 1 || wr_dat[0] !== 8'h05) begin
            n_fail++;
            $display("FAIL tmo_edge: %0d err pulses %0d writes (first %h), required 0 err and one write of 05",
                     err_log.size(), wr_dat.size(), (wr_dat.size() > 0) ? wr_dat[0] : 8'hxx);
        end
    endtask

    task automatic test_tx_full();
        int m;
        clear_logs();
        i_tx_full = 1'b1;
        push_frame(8'h10, 8'h07, 8'h20);
        wait_pops(3, 20, "txfull");
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (o_wr_uart !== 1'b0 || o_w_data !== 8'h17 || o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL txfull_hold: cycle %0d wr=%b wd=%h busy=%b, required wr=0 wd=17 busy=1",
                         i, o_wr_uart, o_w_data, o_busy);
            end
        end
        i_tx_full = 1'b0;
        m = cyc;
        run_quiet(20, "txfull");
        exp_cnt = exp_cnt + 8'd1;
        n_checks++;
        if (wr_dat.size() != 1 || wr_dat[0] !== 8'h17 || wr_cyc[0] > m + 2 || o_cmd_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL txfull_release: %0d writes (first %h) cnt=%0d, required one write of 17 soon after release, cnt=%0d",
                     wr_dat.size(), (wr_dat.size() > 0) ? wr_dat[0] : 8'hxx, o_cmd_cnt, exp_cnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] fb[3];
        logic [7:0] a, b, r;
        logic [5:0] op;
        logic [1:0] hi;
        int k;
        clear_logs();
        for (int f = 0; f < 20; f++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            hi = 2'($urandom);
            op = ($urandom_range(0, 1) == 1) ? 6'h22 : 6'h20;
            r  = (op == 6'h20) ? 8'(a + b) : 8'(a - b);
            exp_q.push_back(r);
            fb[0] = a;
            fb[1] = b;
            fb[2] = {hi, op};
            for (int j = 0; j < 3; j++) begin
                k = $urandom_range(0, 8);
                for (int g = 0; g < k; g++) begin
                    i_tx_full = ($urandom_range(0, 3) == 0);
                    step();
                end
                rx_q.push_back(fb[j]);
                drive_rx();
            end
        end
        k = 0;
        while ((rx_q.size() != 0 || o_busy) && k < 600) begin
            i_tx_full = ($urandom_range(0, 3) == 0);
            step();
            k++;
        end
        i_tx_full = 1'b0;
        run_quiet(20, "random");
        exp_cnt = exp_cnt + 8'd20;
        n_checks++;
        if (wr_dat.size() != exp_q.size() || err_log.size() != 0) begin
            n_fail++;
            $display("FAIL random_count: %0d writes %0d errs, required %0d writes 0 errs",
                     wr_dat.size(), err_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (wr_dat[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random_data[%0d]: got %h, required %h", i, wr_dat[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (o_cmd_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL random_cnt: got %0d, required %0d", o_cmd_cnt, exp_cnt);
        end
    endtask

    task automatic test_cnt_wrap();
        int n;
        clear_logs();
        n = 256 - int'(exp_cnt);
        for (int i = 0; i < n; i++) push_frame(8'(i), 8'h01, 8'h20);
        run_quiet(n * 5 + 50, "wrap");
        exp_cnt = 8'd0;
        n_checks++;
        if (wr_dat.size() != n || o_cmd_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL wrap_cnt: %0d writes cnt=%0d, required %0d writes cnt=0", wr_dat.size(), o_cmd_cnt, n);
        end else begin
            n_checks++;
            if (wr_dat[n - 1] !== 8'(n)) begin
                n_fail++;
                $display("FAIL wrap_data: last write %h, required %h", wr_dat[n - 1], 8'(n));
            end
        end
        clear_logs();
        push_frame(8'h40, 8'h02, 8'h20);
        run_quiet(50, "wrap_next");
        exp_cnt = exp_cnt + 8'd1;
        n_checks++;
        if (o_cmd_cnt !== exp_cnt || wr_dat.size() != 1 || wr_dat[0] !== 8'h42) begin
            n_fail++;
            $display("FAIL wrap_next: cnt=%0d writes=%0d, required cnt=%0d with one write of 42",
                     o_cmd_cnt, wr_dat.size(), exp_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        rx_q.push_back(8'h01);
        rx_q.push_back(8'h02);
        drive_rx();
        wait_pops(2, 10, "rst_mid");
        repeat (3) step();
        #3;
        i_reset = 1'b0;
        #1;
        n_checks++;
        if ({o_rd_uart, o_wr_uart, o_busy, o_err} !== 4'b0000 || o_cmd_cnt !== 8'd0 ||
            o_w_data !== 8'd0 || o_alu_a !== 8'd0 || o_alu_b !== 8'd0 || o_alu_op !== 6'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: rd=%b wr=%b busy=%b err=%b cnt=%0d wd=%h a=%h b=%h op=%h, required all 0",
                     o_rd_uart, o_wr_uart, o_busy, o_err, o_cmd_cnt, o_w_data, o_alu_a, o_alu_b, o_alu_op);
        end
        @(posedge i_clk);
        #1;
        n_checks++;
        if (o_wr_uart !== 1'b0 || o_busy !== 1'b0 || wr_dat.size() != 0) begin
            n_fail++;
            $display("FAIL rst_mid_hold: wr=%b busy=%b writes=%0d, required 0,0,0", o_wr_uart, o_busy, wr_dat.size());
        end
        i_reset = 1'b1;
        exp_cnt = 8'd0;
        clear_logs();
        push_frame(8'h30, 8'h12, 8'h22);
        run_quiet(50, "rst_mid");
        exp_cnt = exp_cnt + 8'd1;
        n_checks++;
        if (wr_dat.size() != 1 || wr_dat[0] !== 8'h1E || o_cmd_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL rst_mid_after: %0d writes (first %h) cnt=%0d, required one write of 1e cnt=1",
                     wr_dat.size(), (wr_dat.size() > 0) ? wr_dat[0] : 8'hxx, o_cmd_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_timeout_edge();
        test_tx_full();
        test_random();
        test_cnt_wrap();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
